// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-S15 memory-side blocks: opcode constants,
// default bus widths and the memory arbiter state encoding.
package wisc_pkg;

    // Memory opcodes decoded into mem_to_reg / reg_to_mem upstream
    localparam logic [3:0] LW = 4'b1000;
    localparam logic [3:0] SW = 4'b1001;

    // Default widths of the unified memory bus
    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;

    // Latency counter geometry; 3 bits covers the legal latency range 1..7
    localparam int CNT_W       = 3;
    localparam int MEM_LAT_DEF = 2;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Value loaded into the latency counter in ISSUE so that the WAIT state
    // lasts exactly mem_lat cycles.
    function automatic logic [CNT_W-1:0] lat_load_value(input int mem_lat);
        return CNT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified
// memory. The arbiter uses the slave view; the pipeline/memory side uses the
// master view.
interface mem_arbiter_if
    import wisc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // Instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    // Data port (LW / SW)
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    // Pipeline hold
    logic              stall;

    // Unified memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency. It saturates at
// zero so a stray decrement can never wrap into a long bogus wait.
module mem_lat_cnt
    import wisc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified memory of the WISC-S15 pipeline.
// Data accesses win over instruction fetch because they belong to the older
// instruction; the fetch side simply stalls until the data port is quiet.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; pick a winner and latch its request
// ISSUE | mem_en strobe is on the bus; latency counter is loaded
// WAIT  | counting down the memory latency; capture read data at zero
// DONE  | one-cycle ack to the winner, then back to IDLE
module mem_arbiter
    import wisc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_check
        $error("mem_arbiter: MEM_LAT must be within 1..7");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load_value(MEM_LAT);

    arb_state_t state;
    arb_state_t state_next;

    logic d_req;
    logic grant;
    logic access_end;
    logic cnt_load;
    logic cnt_dec;
    logic lat_zero;

    // Latched request of the current winner
    logic              grantee_data;
    logic              we_lat;

    // Registered outputs
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Request decode; a simultaneous read and write is a write
    always_comb begin
        d_req      = bus.d_rd | bus.d_wr;
        grant      = (state == IDLE) & (d_req | bus.if_req);
        access_end = (state == WAIT) & lat_zero;
        cnt_load   = (state == ISSUE);
        cnt_dec    = (state == WAIT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (d_req || bus.if_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (lat_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    mem_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (lat_zero)
    );

    // Latch the winner and drive the memory strobe for exactly the ISSUE cycle.
    // Later changes on the request inputs are invisible until the next IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grantee_data <= 1'b0;
            we_lat       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (grant) begin
                grantee_data <= d_req;
                we_lat       <= bus.d_wr;
                mem_en_q     <= 1'b1;
                mem_we_q     <= bus.d_wr;
                if (d_req) begin
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                end else begin
                    mem_addr_q  <= bus.if_addr;
                end
            end
        end
    end

    // Capture read data on the last WAIT cycle and raise the winner's ack for
    // the DONE cycle. Writes leave the read data registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (access_end) begin
                if (grantee_data) begin
                    d_ack_q <= 1'b1;
                    if (!we_lat) begin
                        d_rdata_q <= bus.mem_rdata;
                    end
                end else begin
                    if_ack_q <= 1'b1;
                    if (!we_lat) begin
                        if_rdata_q <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Hold the pipeline while any request is still waiting for its ack
    assign bus.stall = (d_req & ~d_ack_q) | (bus.if_req & ~if_ack_q);

endmodule
